// File: rtl/chroma_transform_pipe.sv
// chroma_transform_pipe: five-stage luma-dependent nonlinear Cb/Cr transform
// with valid/ready back-pressure and an external synchronous mean/width LUT.
// Optional saturation counter: define CHROMA_SAT_CNT_EN to add sat_clr/sat_count.
module chroma_transform_pipe #(
  parameter int DATA_W    = 8,
  parameter int WID_W     = 8,
  parameter int WID_FRAC  = 6,
  parameter int K_L       = 125,
  parameter int K_H       = 188,
  parameter int CB_CENTER = 108,
  parameter int CR_CENTER = 154
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_cb,
  input  logic [DATA_W-1:0] in_cr,
  output logic              lut_en,
  output logic [DATA_W-1:0] lut_y,
  input  logic [DATA_W-1:0] lut_mean_cb,
  input  logic [WID_W-1:0]  lut_wid_cb,
  input  logic [DATA_W-1:0] lut_mean_cr,
  input  logic [WID_W-1:0]  lut_wid_cr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_cb,
  output logic [DATA_W-1:0] out_cr
`ifdef CHROMA_SAT_CNT_EN
  ,
  input  logic              sat_clr,
  output logic [15:0]       sat_count
`endif
);

  localparam int DW1 = DATA_W + 1;
  localparam int PW  = DATA_W + WID_W + 1;
  localparam int SW  = PW + 1;

  localparam logic [DATA_W-1:0] KL  = DATA_W'(K_L);
  localparam logic [DATA_W-1:0] KH  = DATA_W'(K_H);
  localparam logic [DATA_W-1:0] CBC = DATA_W'(CB_CENTER);
  localparam logic [DATA_W-1:0] CRC = DATA_W'(CR_CENTER);

  logic adv;

  logic                     v0_q, v1_q, v2_q, v3_q, v4_q;
  logic [DATA_W-1:0]        y0_q, lut_y_q;
  logic [DATA_W-1:0]        cb0_q, cr0_q, cb1_q, cr1_q, cb2_q, cr2_q;
  logic [DATA_W-1:0]        cb3_q, cr3_q, cb4_q, cr4_q;
  logic                     pass1_q, pass2_q, pass3_q, pass4_q;
  logic signed [DW1-1:0]    dcb2_q, dcr2_q, dcb_d, dcr_d;
  logic [WID_W-1:0]         wcb2_q, wcr2_q;
  logic signed [PW-1:0]     pcb3_q, pcr3_q, pcb_d, pcr_d;
  logic signed [SW-1:0]     scb4_q, scr4_q, scb_d, scr_d;
  logic                     out_valid_q;
  logic [DATA_W-1:0]        out_cb_q, out_cr_q, out_cb_d, out_cr_d;
  logic [DATA_W:0]          clip_cb, clip_cr;
  logic                     sat_d;

  // Returns {saturated, clipped value} for a signed sum.
  function automatic logic [DATA_W:0] clip(input logic signed [SW-1:0] s);
    if (s[SW-1])
      clip = {1'b1, {DATA_W{1'b0}}};
    else if (|s[SW-2:DATA_W])
      clip = {1'b1, {DATA_W{1'b1}}};
    else
      clip = {1'b0, s[DATA_W-1:0]};
  endfunction

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign lut_en    = adv;
  assign lut_y     = lut_y_q;
  assign out_valid = out_valid_q;
  assign out_cb    = out_cb_q;
  assign out_cr    = out_cr_q;

  // Stage arithmetic: difference, scaled product, shifted and re-centred sum, clip/select.
  always_comb begin
    dcb_d    = $signed({1'b0, cb1_q}) - $signed({1'b0, lut_mean_cb});
    dcr_d    = $signed({1'b0, cr1_q}) - $signed({1'b0, lut_mean_cr});
    pcb_d    = PW'(dcb2_q) * PW'($signed({1'b0, wcb2_q}));
    pcr_d    = PW'(dcr2_q) * PW'($signed({1'b0, wcr2_q}));
    scb_d    = SW'(pcb3_q >>> WID_FRAC) + SW'($signed({1'b0, CBC}));
    scr_d    = SW'(pcr3_q >>> WID_FRAC) + SW'($signed({1'b0, CRC}));
    clip_cb  = clip(scb4_q);
    clip_cr  = clip(scr4_q);
    out_cb_d = pass4_q ? cb4_q : clip_cb[DATA_W-1:0];
    out_cr_d = pass4_q ? cr4_q : clip_cr[DATA_W-1:0];
    sat_d    = !pass4_q && (clip_cb[DATA_W] || clip_cr[DATA_W]);
  end

  // S0/S1: register the pixel and LUT address, then flag the pass-through luma band.
  // The LUT reads lut_y on the edge that moves the pixel into S1, so its data lines
  // up with S1 and is consumed by the S1->S2 transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q    <= 1'b0;
      y0_q    <= '0;
      cb0_q   <= '0;
      cr0_q   <= '0;
      lut_y_q <= '0;
      v1_q    <= 1'b0;
      cb1_q   <= '0;
      cr1_q   <= '0;
      pass1_q <= 1'b0;
    end else if (adv) begin
      v0_q    <= in_valid;
      y0_q    <= in_y;
      cb0_q   <= in_cb;
      cr0_q   <= in_cr;
      lut_y_q <= in_y;
      v1_q    <= v0_q;
      cb1_q   <= cb0_q;
      cr1_q   <= cr0_q;
      pass1_q <= (y0_q >= KL) && (y0_q <= KH);
    end
  end

  // S2/S3/S4: chroma minus mean with captured width, product, then shifted sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      dcb2_q  <= '0;
      dcr2_q  <= '0;
      wcb2_q  <= '0;
      wcr2_q  <= '0;
      cb2_q   <= '0;
      cr2_q   <= '0;
      pass2_q <= 1'b0;
      v3_q    <= 1'b0;
      pcb3_q  <= '0;
      pcr3_q  <= '0;
      cb3_q   <= '0;
      cr3_q   <= '0;
      pass3_q <= 1'b0;
      v4_q    <= 1'b0;
      scb4_q  <= '0;
      scr4_q  <= '0;
      cb4_q   <= '0;
      cr4_q   <= '0;
      pass4_q <= 1'b0;
    end else if (adv) begin
      v2_q    <= v1_q;
      dcb2_q  <= dcb_d;
      dcr2_q  <= dcr_d;
      wcb2_q  <= lut_wid_cb;
      wcr2_q  <= lut_wid_cr;
      cb2_q   <= cb1_q;
      cr2_q   <= cr1_q;
      pass2_q <= pass1_q;
      v3_q    <= v2_q;
      pcb3_q  <= pcb_d;
      pcr3_q  <= pcr_d;
      cb3_q   <= cb2_q;
      cr3_q   <= cr2_q;
      pass3_q <= pass2_q;
      v4_q    <= v3_q;
      scb4_q  <= scb_d;
      scr4_q  <= scr_d;
      cb4_q   <= cb3_q;
      cr4_q   <= cr3_q;
      pass4_q <= pass3_q;
    end
  end

  // Output register: saturation and pass-through select land here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_cb_q    <= '0;
      out_cr_q    <= '0;
    end else if (adv) begin
      out_valid_q <= v4_q;
      out_cb_q    <= out_cb_d;
      out_cr_q    <= out_cr_d;
    end
  end

`ifdef CHROMA_SAT_CNT_EN
  logic        out_sat_q;
  logic [15:0] sat_cnt_q;

  assign sat_count = sat_cnt_q;

  // Saturation flag travels with the output pixel; counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat_q <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      if (adv)
        out_sat_q <= sat_d;
      if (sat_clr)
        sat_cnt_q <= '0;
      else if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != '1))
        sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_d;
`endif

endmodule
